data_bus_ctrl: RTL and testbench

- Sequences all CPU load/store traffic and shares it between data RAM (mem_control) and the USB FIFO register interface (fifo_if).
- Decodes each request, issues single-cycle strobes to the selected target, waits for completion, returns one response and stalls the PC meanwhile.
- Also holds a 2-bit IRQ-enable register and raises the combined FIFO interrupt.
- Sits between the control unit/ALU address path and the two memory-side blocks inside cpu.

---
 rtl/bus_pkg.sv | 37 +++
 rtl/io_addr_decode.sv | 36 +++
 rtl/data_bus_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_data_bus_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU data bus controller: FSM states,
// access-size codes, IO window offsets and the alignment helper.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    FIFO_CAP = 3'd2,
    RAM_WAIT = 3'd3,
    RESP     = 3'd4
  } bus_state_e;

  // Access-size encoding; must match the ACC_* defines used by mem_control.
  localparam logic [1:0] ACC_BYTE = 2'd0;
  localparam logic [1:0] ACC_HALF = 2'd1;
  localparam logic [1:0] ACC_WORD = 2'd2;
  localparam logic [1:0] ACC_ILL  = 2'd3;

  localparam logic [31:0] IO_BASE_DEF = 32'hF000_0000;
  localparam logic [11:0] IEN_OFF_DEF = 12'h010;

  localparam logic [11:0] FIFO_OFF_0 = 12'h000;
  localparam logic [11:0] FIFO_OFF_1 = 12'h004;
  localparam logic [11:0] FIFO_OFF_2 = 12'h008;
  localparam logic [11:0] FIFO_OFF_3 = 12'h00C;

  function automatic logic misaligned(input logic [1:0] acc, input logic [1:0] lsb);
    logic bad;
    case (acc)
      ACC_HALF: bad = lsb[0];
      ACC_WORD: bad = (lsb != 2'd0);
      default:  bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/io_addr_decode.sv
// Combinational request decode: IO window hit, IRQ-enable register hit,
// FIFO register index and the combined error flag.
module io_addr_decode
  import bus_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEF,
  parameter logic [11:0] IEN_OFF = IEN_OFF_DEF
) (
  input  logic [31:0] addr_i,
  input  logic [1:0]  acc_i,
  output logic        is_io_o,
  output logic        is_ien_o,
  output logic [1:0]  fifo_idx_o,
  output logic        err_o
);

  localparam logic [19:0] IO_PAGE = IO_BASE[31:12];

  logic [11:0] off_s;
  logic        fifo_hit_s;

  assign off_s = addr_i[11:0];

  // Address classification and error detection
  always_comb begin
    is_io_o    = (addr_i[31:12] == IO_PAGE);
    is_ien_o   = is_io_o && (off_s == IEN_OFF);
    fifo_hit_s = (off_s == FIFO_OFF_0) || (off_s == FIFO_OFF_1) ||
                 (off_s == FIFO_OFF_2) || (off_s == FIFO_OFF_3);
    fifo_idx_o = addr_i[3:2];
    // IO registers are word-spaced, so any IO access must be word aligned
    err_o      = (acc_i == ACC_ILL) || misaligned(acc_i, addr_i[1:0]) ||
                 (is_io_o && ((addr_i[1:0] != 2'd0) || !(fifo_hit_s || is_ien_o)));
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// CPU load/store sequencer sharing the data bus between data RAM and the
// USB FIFO register block; also owns the FIFO IRQ-enable register.
module data_bus_ctrl
  import bus_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEF,
  parameter logic [11:0] IEN_OFF = IEN_OFF_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_acc_i,
  input  logic        req_sext_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        stall_o,
  output logic [31:0] ram_addr_o,
  output logic [1:0]  ram_acc_r_o,
  output logic [1:0]  ram_acc_w_o,
  output logic        ram_sext_o,
  output logic        ram_wr_en_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  input  logic        ram_wr_ready_i,
  output logic        fifo_sel_o,
  output logic        fifo_rd_o,
  output logic        fifo_wr_o,
  output logic [1:0]  fifo_addr_o,
  output logic [7:0]  fifo_wrdata_o,
  input  logic [7:0]  fifo_rddata_i,
  input  logic        fifo_in_irq_i,
  input  logic        fifo_out_irq_i,
  output logic        irq_o
);

  bus_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        we_q, we_d, sext_q, sext_d;
  logic [1:0]  acc_q, acc_d, fidx_q, fidx_d;
  logic        io_q, io_d, ien_hit_q, ien_hit_d;
  logic [1:0]  ien_q, ien_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        ram_wr_en_q, ram_wr_en_d;
  logic        fifo_sel_q, fifo_sel_d, fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;

  logic        dec_io_s, dec_ien_s, dec_err_s;
  logic [1:0]  dec_fidx_s;

  io_addr_decode #(.IO_BASE(IO_BASE), .IEN_OFF(IEN_OFF)) u_dec (
    .addr_i     (req_addr_i),
    .acc_i      (req_acc_i),
    .is_io_o    (dec_io_s),
    .is_ien_o   (dec_ien_s),
    .fifo_idx_o (dec_fidx_s),
    .err_o      (dec_err_s)
  );

  // Next-state, request latches and registered-output next values
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    sext_d      = sext_q;
    acc_d       = acc_q;
    fidx_d      = fidx_q;
    io_d        = io_q;
    ien_hit_d   = ien_hit_q;
    ien_d       = ien_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = 32'd0;
    ram_wr_en_d = 1'b0;
    fifo_sel_d  = 1'b0;
    fifo_rd_d   = 1'b0;
    fifo_wr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i;
          we_d      = req_we_i;
          sext_d    = req_sext_i;
          acc_d     = req_acc_i;
          fidx_d    = dec_fidx_s;
          io_d      = dec_io_s;
          ien_hit_d = dec_ien_s;
          if (dec_err_s) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
            // Strobes are registered, so they are raised here to appear in ISSUE
            if (dec_io_s && !dec_ien_s) begin
              fifo_sel_d = 1'b1;
              fifo_rd_d  = !req_we_i;
              fifo_wr_d  = req_we_i;
            end else begin
              ram_wr_en_d = req_we_i && !dec_io_s;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (io_q && ien_hit_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          if (we_q) begin
            ien_d = wdata_q[1:0];
          end else begin
            rsp_data_d = {30'd0, ien_q};
          end
        end else if (io_q) begin
          state_d = FIFO_CAP;
        end else begin
          state_d     = RAM_WAIT;
          ram_wr_en_d = we_q;
        end
      end
      FIFO_CAP: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        if (we_q) begin
          rsp_data_d = 32'd0;
        end else begin
          rsp_data_d = {24'd0, fifo_rddata_i};
        end
      end
      RAM_WAIT: begin
        if (!we_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = ram_rdata_i;
        end else if (ram_wr_ready_i) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          ram_wr_en_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latches and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
      sext_q      <= 1'b0;
      acc_q       <= 2'd0;
      fidx_q      <= 2'd0;
      io_q        <= 1'b0;
      ien_hit_q   <= 1'b0;
      ien_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'd0;
      ram_wr_en_q <= 1'b0;
      fifo_sel_q  <= 1'b0;
      fifo_rd_q   <= 1'b0;
      fifo_wr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      sext_q      <= sext_d;
      acc_q       <= acc_d;
      fidx_q      <= fidx_d;
      io_q        <= io_d;
      ien_hit_q   <= ien_hit_d;
      ien_q       <= ien_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      ram_wr_en_q <= ram_wr_en_d;
      fifo_sel_q  <= fifo_sel_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_wr_q   <= fifo_wr_d;
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_o     = rsp_err_q;
  assign stall_o       = req_valid_i & ~rsp_valid_q;
  assign ram_addr_o    = addr_q;
  assign ram_acc_r_o   = acc_q;
  assign ram_acc_w_o   = acc_q;
  assign ram_sext_o    = sext_q;
  assign ram_wr_en_o   = ram_wr_en_q;
  assign ram_wdata_o   = wdata_q;
  assign fifo_sel_o    = fifo_sel_q;
  assign fifo_rd_o     = fifo_rd_q;
  assign fifo_wr_o     = fifo_wr_q;
  assign fifo_addr_o   = fidx_q;
  assign fifo_wrdata_o = wdata_q[7:0];
  assign irq_o         = (fifo_in_irq_i & ien_q[0]) | (fifo_out_irq_i & ien_q[1]);

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Scoreboard bench for data_bus_ctrl: expected responses are queued when a
// request is driven and compared when rsp_valid_o appears.
module tb_data_bus_ctrl;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0, req_sext_i = 1'b0;
  logic [31:0] req_addr_i = 32'd0, req_wdata_i = 32'd0;
  logic [1:0]  req_acc_i = 2'd0;
  logic        rsp_valid_o, rsp_err_o, stall_o;
  logic [31:0] rsp_data_o, ram_addr_o, ram_wdata_o;
  logic [1:0]  ram_acc_r_o, ram_acc_w_o;
  logic        ram_sext_o, ram_wr_en_o;
  logic [31:0] ram_rdata_i = 32'd0;
  logic        ram_wr_ready_i = 1'b0;
  logic        fifo_sel_o, fifo_rd_o, fifo_wr_o;
  logic [1:0]  fifo_addr_o;
  logic [7:0]  fifo_wrdata_o;
  logic [7:0]  fifo_rddata_i = 8'hA5;
  logic        fifo_in_irq_i = 1'b0, fifo_out_irq_i = 1'b0;
  logic        irq_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int ready_low = 0;
  int wr_cnt = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic        err;
    bit          stall_ok;
    int          n_sel, n_rd, n_wr, n_ram, n_both;
    logic [1:0]  faddr;
    logic [7:0]  fwdata;
    bit          wstable;
    bit          tmo;
  } obs_t;

  data_bus_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_acc_i(req_acc_i), .req_sext_i(req_sext_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .stall_o(stall_o), .ram_addr_o(ram_addr_o), .ram_acc_r_o(ram_acc_r_o),
    .ram_acc_w_o(ram_acc_w_o), .ram_sext_o(ram_sext_o), .ram_wr_en_o(ram_wr_en_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_wr_ready_i(ram_wr_ready_i),
    .fifo_sel_o(fifo_sel_o), .fifo_rd_o(fifo_rd_o), .fifo_wr_o(fifo_wr_o),
    .fifo_addr_o(fifo_addr_o), .fifo_wrdata_o(fifo_wrdata_o), .fifo_rddata_i(fifo_rddata_i),
    .fifo_in_irq_i(fifo_in_irq_i), .fifo_out_irq_i(fifo_out_irq_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // RAM write responder: ready rises after ready_low cycles of write enable
  always @(negedge clk) begin
    if (ram_wr_en_o) begin
      wr_cnt = wr_cnt + 1;
      ram_wr_ready_i = (wr_cnt > ready_low);
    end else begin
      wr_cnt = 0;
      ram_wr_ready_i = 1'b0;
    end
  end

  // Drive one request from just after a rising edge and observe until the response
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] acc, output obs_t o);
    o = '{lat: -1, data: 32'hX, err: 1'bX, stall_ok: 1'b1, n_sel: 0, n_rd: 0, n_wr: 0,
          n_ram: 0, n_both: 0, faddr: 2'd0, fwdata: 8'd0, wstable: 1'b1, tmo: 1'b1};
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_acc_i   = acc;
    req_sext_i  = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (fifo_sel_o) begin
        o.n_sel++;
        o.faddr  = fifo_addr_o;
        o.fwdata = fifo_wrdata_o;
      end
      if (fifo_rd_o) o.n_rd++;
      if (fifo_wr_o) o.n_wr++;
      if (ram_wr_en_o && (fifo_sel_o || fifo_rd_o || fifo_wr_o)) o.n_both++;
      if (ram_wr_en_o) begin
        o.n_ram++;
        if (ram_wdata_o !== wdata || ram_addr_o !== addr) o.wstable = 1'b0;
      end
      if (rsp_valid_o) begin
        o.lat  = c;
        o.data = rsp_data_o;
        o.err  = rsp_err_o;
        o.tmo  = 1'b0;
        if (stall_o !== 1'b0) o.stall_ok = 1'b0;
      end else if (stall_o !== 1'b1) begin
        o.stall_ok = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!o.tmo) break;
    end
    req_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    fifo_in_irq_i = 1'b1;
    fifo_out_irq_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({rsp_valid_o, rsp_err_o, ram_wr_en_o, fifo_sel_o, fifo_rd_o, fifo_wr_o} !== 6'd0)
      $display("FAIL reset_strobes got=%b want=000000", {rsp_valid_o, rsp_err_o, ram_wr_en_o, fifo_sel_o, fifo_rd_o, fifo_wr_o}); else pass_cnt++;
    chk_cnt++; if ({rsp_data_o, ram_addr_o, ram_acc_r_o, ram_acc_w_o} !== 68'd0)
      $display("FAIL reset_data got=%h/%h/%0d/%0d want=0", rsp_data_o, ram_addr_o, ram_acc_r_o, ram_acc_w_o); else pass_cnt++;
    chk_cnt++; if (irq_o !== 1'b0) $display("FAIL reset_irq got=%b want=0", irq_o); else pass_cnt++;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL reset_stall got=%b want=0", stall_o); else pass_cnt++;
    fifo_in_irq_i = 1'b0;
    fifo_out_irq_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ram_load();
    obs_t o;
    exp_t e;
    ram_rdata_i = 32'hDEADBEEF;
    sb.push_back('{data: 32'hDEADBEEF, err: 1'b0, lat: 3});
    send(1'b0, 32'h0000_0100, 32'd0, ACC_WORD, o);
    e = sb.pop_front();
    chk_cnt++; if (o.tmo) $display("FAIL load_timeout no response"); else pass_cnt++;
    chk_cnt++; if (o.lat !== e.lat) $display("FAIL load_lat got=%0d want=%0d", o.lat, e.lat); else pass_cnt++;
    chk_cnt++; if (o.data !== e.data || o.err !== e.err)
      $display("FAIL load_data got=%h/%b want=%h/%b", o.data, o.err, e.data, e.err); else pass_cnt++;
    chk_cnt++; if (!o.stall_ok) $display("FAIL load_stall got=bad want=high until rsp"); else pass_cnt++;
  endtask

  task automatic test_ram_store_bp();
    obs_t o;
    exp_t e;
    ready_low = 3;
    sb.push_back('{data: 32'd0, err: 1'b0, lat: 5});
    send(1'b1, 32'h0000_0204, 32'h1234_5678, ACC_WORD, o);
    e = sb.pop_front();
    chk_cnt++; if (o.lat !== e.lat) $display("FAIL store_lat got=%0d want=%0d", o.lat, e.lat); else pass_cnt++;
    chk_cnt++; if (o.data !== e.data || o.err !== e.err)
      $display("FAIL store_data got=%h/%b want=%h/%b", o.data, o.err, e.data, e.err); else pass_cnt++;
    chk_cnt++; if (o.n_ram !== 4 || !o.wstable)
      $display("FAIL store_hold got=%0d cycles stable=%0d want=4 stable=1", o.n_ram, o.wstable); else pass_cnt++;
    chk_cnt++; if (o.n_sel !== 0) $display("FAIL store_fifo got=%0d want=0", o.n_sel); else pass_cnt++;
  endtask

  task automatic test_fifo_read();
    obs_t o;
    exp_t e;
    fifo_rddata_i = 8'hA5;
    sb.push_back('{data: 32'h0000_00A5, err: 1'b0, lat: 3});
    send(1'b0, 32'hF000_0004, 32'd0, ACC_BYTE, o);
    e = sb.pop_front();
    chk_cnt++; if (o.lat !== e.lat || o.data !== e.data || o.err !== e.err)
      $display("FAIL fifo_rd_rsp got=%0d/%h/%b want=%0d/%h/%b", o.lat, o.data, o.err, e.lat, e.data, e.err); else pass_cnt++;
    chk_cnt++; if (o.n_sel !== 1 || o.n_rd !== 1 || o.n_wr !== 0 || o.faddr !== 2'd1)
      $display("FAIL fifo_rd_strobe got=sel%0d rd%0d wr%0d a%0d want=sel1 rd1 wr0 a1", o.n_sel, o.n_rd, o.n_wr, o.faddr); else pass_cnt++;
    chk_cnt++; if (o.n_ram !== 0) $display("FAIL fifo_rd_ram got=%0d want=0", o.n_ram); else pass_cnt++;
  endtask

  task automatic test_ien_irq();
    obs_t o;
    exp_t e;
    sb.push_back('{data: 32'd0, err: 1'b0, lat: 2});
    send(1'b1, 32'hF000_0010, 32'h0000_0002, ACC_WORD, o);
    e = sb.pop_front();
    chk_cnt++; if (o.lat !== e.lat || o.data !== e.data || o.err !== e.err || o.n_sel !== 0 || o.n_ram !== 0)
      $display("FAIL ien_wr got=%0d/%h/%b sel%0d ram%0d want=%0d/%h/%b sel0 ram0", o.lat, o.data, o.err, o.n_sel, o.n_ram, e.lat, e.data, e.err); else pass_cnt++;
    fifo_out_irq_i = 1'b1;
    @(negedge clk);
    chk_cnt++; if (irq_o !== 1'b1) $display("FAIL irq_out got=%b want=1", irq_o); else pass_cnt++;
    fifo_out_irq_i = 1'b0;
    fifo_in_irq_i = 1'b1;
    @(negedge clk);
    chk_cnt++; if (irq_o !== 1'b0) $display("FAIL irq_in_masked got=%b want=0", irq_o); else pass_cnt++;
    fifo_in_irq_i = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back('{data: 32'h0000_0002, err: 1'b0, lat: 2});
    send(1'b0, 32'hF000_0010, 32'd0, ACC_WORD, o);
    e = sb.pop_front();
    chk_cnt++; if (o.lat !== e.lat || o.data !== e.data)
      $display("FAIL ien_rd got=%0d/%h want=%0d/%h", o.lat, o.data, e.lat, e.data); else pass_cnt++;
  endtask

  task automatic test_errors();
    obs_t o;
    exp_t e;
    logic [31:0] a;
    logic [1:0]  acc;
    logic        we;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin a = 32'h0000_0101; acc = ACC_HALF; we = 1'b0; end
        1: begin a = 32'hF000_0020; acc = ACC_WORD; we = 1'b0; end
        2: begin a = 32'hF000_0005; acc = ACC_BYTE; we = 1'b1; end
        3: begin a = 32'h0000_0200; acc = ACC_ILL;  we = 1'b1; end
        default: begin a = 32'h0000_0102; acc = ACC_WORD; we = 1'b1; end
      endcase
      sb.push_back('{data: 32'd0, err: 1'b1, lat: 1});
      send(we, a, 32'hFFFF_FFFF, acc, o);
      e = sb.pop_front();
      chk_cnt++; if (o.lat !== e.lat || o.data !== e.data || o.err !== e.err)
        $display("FAIL err_rsp_%0d got=%0d/%h/%b want=%0d/%h/%b", i, o.lat, o.data, o.err, e.lat, e.data, e.err); else pass_cnt++;
      chk_cnt++; if (o.n_sel !== 0 || o.n_ram !== 0)
        $display("FAIL err_strobe_%0d got=sel%0d ram%0d want=0", i, o.n_sel, o.n_ram); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    ready_low = 0;
    ram_rdata_i = 32'h0BAD_F00D;
    sb.push_back('{data: 32'd0, err: 1'b0, lat: 3});
    sb.push_back('{data: 32'h0BAD_F00D, err: 1'b0, lat: 3});
    sb.push_back('{data: 32'd0, err: 1'b0, lat: 3});
    send(1'b1, 32'h0000_0300, 32'hCAFE_0001, ACC_WORD, o);
    e = sb.pop_front();
    chk_cnt++; if (o.lat !== e.lat || o.data !== e.data || o.n_ram !== 2)
      $display("FAIL b2b_store got=%0d/%h ram%0d want=%0d/%h ram2", o.lat, o.data, o.n_ram, e.lat, e.data); else pass_cnt++;
    send(1'b0, 32'h0000_0300, 32'd0, ACC_WORD, o);
    e = sb.pop_front();
    chk_cnt++; if (o.lat !== e.lat || o.data !== e.data || o.err !== e.err)
      $display("FAIL b2b_load got=%0d/%h/%b want=%0d/%h/%b", o.lat, o.data, o.err, e.lat, e.data, e.err); else pass_cnt++;
    send(1'b1, 32'hF000_000C, 32'h1111_225A, ACC_BYTE, o);
    e = sb.pop_front();
    chk_cnt++; if (o.lat !== e.lat || o.data !== e.data || o.n_sel !== 1 || o.n_wr !== 1 || o.n_rd !== 0 ||
                   o.faddr !== 2'd3 || o.fwdata !== 8'h5A || o.n_both !== 0)
      $display("FAIL b2b_fifo_wr got=%0d/%h sel%0d wr%0d rd%0d a%0d d%h both%0d want=%0d/%h sel1 wr1 rd0 a3 d5a both0",
               o.lat, o.data, o.n_sel, o.n_wr, o.n_rd, o.faddr, o.fwdata, o.n_both, e.lat, e.data); else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    obs_t o;
    exp_t e;
    sb.push_back('{data: 32'd0, err: 1'b0, lat: 2});
    send(1'b1, 32'hF000_0010, 32'h0000_0003, ACC_WORD, o);
    e = sb.pop_front();
    chk_cnt++; if (o.lat !== e.lat) $display("FAIL rmw_ien_set got=%0d want=%0d", o.lat, e.lat); else pass_cnt++;
    ready_low = 1000;
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 32'h0000_0400;
    req_wdata_i = 32'hA5A5_5A5A;
    req_acc_i   = ACC_WORD;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (ram_wr_en_o !== 1'b1) $display("FAIL rmw_pending got=%b want=1", ram_wr_en_o); else pass_cnt++;
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    fifo_in_irq_i = 1'b1;
    fifo_out_irq_i = 1'b1;
    @(negedge clk);
    chk_cnt++; if (ram_wr_en_o !== 1'b0 || rsp_valid_o !== 1'b0)
      $display("FAIL rmw_drop got=wr%b rsp%b want=wr0 rsp0", ram_wr_en_o, rsp_valid_o); else pass_cnt++;
    chk_cnt++; if (irq_o !== 1'b0) $display("FAIL rmw_ien_clr got=%b want=0", irq_o); else pass_cnt++;
    fifo_in_irq_i = 1'b0;
    fifo_out_irq_i = 1'b0;
    ready_low = 0;
    @(posedge clk);
    #1;
    sb.push_back('{data: 32'd0, err: 1'b0, lat: 2});
    send(1'b0, 32'hF000_0010, 32'd0, ACC_WORD, o);
    e = sb.pop_front();
    chk_cnt++; if (o.lat !== e.lat || o.data !== e.data)
      $display("FAIL rmw_idle got=%0d/%h want=%0d/%h", o.lat, o.data, e.lat, e.data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_ram_load();
    test_ram_store_bp();
    test_fifo_read();
    test_ien_irq();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
